// File: rtl/mem_port_arbiter.sv
// Purpose: shares one single-port word memory between I-fetch and D ports, one access at a time.
// Latency: request sampled -> done after LATENCY+1 edges; one access per LATENCY+2 cycles.
// Backpressure: requester holds req until its done; ARB_ROUND_ROBIN_EN alternates contested grants.
module mem_port_arbiter #(
  parameter int LATENCY = 2,
  parameter int AW      = 32,
  parameter int DW      = 32
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_done,
  output logic [DW-1:0] i_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_done,
  output logic [DW-1:0] d_rdata,
  output logic          mem_ren,
  output logic          mem_wen,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout,
  output logic          busy
);

  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          owner_d, we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic          start, grant_d, last_cycle;
  logic          ren_nxt, wen_nxt;

  assign start      = i_req | d_req;
  assign last_cycle = (state == ACCESS) && (cnt == '0);

`ifdef ARB_ROUND_ROBIN_EN
  // Reset favours D so the first contested grant goes to the older instruction.
  logic prefer_d;

  assign grant_d = d_req & (~i_req | prefer_d);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prefer_d <= 1'b1;
    end else if (state == IDLE && start) begin
      prefer_d <= ~grant_d;
    end
  end
`else
  assign grant_d = d_req;
`endif

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ren_nxt   = 1'b0;
    wen_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = ACCESS;
          cnt_nxt   = CW'(LATENCY - 1);
          wen_nxt   = grant_d & d_we;
          ren_nxt   = ~(grant_d & d_we);
        end
      end
      ACCESS: begin
        if (cnt == '0) begin
          state_nxt = DONE;
        end else begin
          cnt_nxt = cnt - CW'(1);
          ren_nxt = ~we_q;
          wen_nxt = we_q;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      owner_d <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      mem_ren <= 1'b0;
      mem_wen <= 1'b0;
      i_done  <= 1'b0;
      d_done  <= 1'b0;
      i_rdata <= '0;
      d_rdata <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      mem_ren <= ren_nxt;
      mem_wen <= wen_nxt;
      i_done  <= last_cycle & ~owner_d;
      d_done  <= last_cycle & owner_d;
      if (state == IDLE && start) begin
        owner_d <= grant_d;
        we_q    <= grant_d & d_we;
        addr_q  <= grant_d ? d_addr : i_addr;
        wdata_q <= grant_d ? d_wdata : '0;
      end
      if (last_cycle && !owner_d) begin
        i_rdata <= mem_dout;
      end
      if (last_cycle && owner_d && !we_q) begin
        d_rdata <= mem_dout;
      end
    end
  end

  assign mem_addr = addr_q;
  assign mem_din  = wdata_q;
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed accesses against a transaction-schedule model.
// Each scheduled access owns a window of enable cycles followed by one done cycle.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
  localparam int L = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0;
  logic        i_done, d_done, mem_ren, mem_wen, busy;
  logic [31:0] i_rdata, d_rdata, mem_addr, mem_din, mem_dout;

  mem_port_arbiter #(.LATENCY(L), .AW(32), .DW(32)) dut (
    .clock(clock), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done), .d_rdata(d_rdata),
    .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout), .busy(busy)
  );

  always #5 clock = ~clock;

  // Word memory, combinational read; preload port used only while the arbiter is idle.
  logic [31:0] mem [0:255];
  logic        pl_en = 1'b0;
  logic [7:0]  pl_addr = '0;
  logic [31:0] pl_dat = '0;
  assign mem_dout = mem[mem_addr[7:0]];
  always @(posedge clock) begin
    if (pl_en) mem[pl_addr] <= pl_dat;
    else if (mem_wen) mem[mem_addr[7:0]] <= mem_din;
  end

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  assert property (@(posedge clock) disable iff (!reset) !(mem_ren && mem_wen))
    else $error("ren and wen high together");
  assert property (@(posedge clock) disable iff (!reset)
    ((mem_ren || mem_wen) && $past(mem_ren || mem_wen)) |-> $stable(mem_addr))
    else $error("mem_addr moved during an access");

  typedef struct {
    int          done;
    bit          is_d;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rd_i;
    logic [31:0] rd_d;
  } txn_t;

  txn_t        sched[$];
  int          head = 0;
  logic [31:0] ref_mem [0:255];
  logic [31:0] last_i = '0, last_d = '0;
  logic [7:0]  done_log = '0;
  bit          cmp_on = 1'b1;
  int          n_vec = 0, n_err = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, got, want, cyc);
    end
  endtask

  // Model: the access is sampled at edge s, drives memory for L cycles, done shows on edge s+L.
  task automatic expect_txn(input bit is_d, input bit we, input logic [31:0] a,
                            input logic [31:0] wd, input int s);
    txn_t t;
    if (we) ref_mem[a[7:0]] = wd;
    else if (is_d) last_d = ref_mem[a[7:0]];
    else last_i = ref_mem[a[7:0]];
    t.done = s + L; t.is_d = is_d; t.we = we; t.addr = a; t.wdata = wd;
    t.rd_i = last_i; t.rd_d = last_d;
    sched.push_back(t);
  endtask

  task automatic compare();
    logic e_busy, e_ren, e_wen, e_i, e_d;
    txn_t t;
    e_busy = 0; e_ren = 0; e_wen = 0; e_i = 0; e_d = 0;
    if (head < sched.size()) begin
      t = sched[head];
      if (cyc >= t.done - L && cyc < t.done) begin
        e_busy = 1; e_ren = !t.we; e_wen = t.we;
        chk("mem_addr", mem_addr, t.addr);
        if (t.we) chk("mem_din", mem_din, t.wdata);
      end
      if (cyc == t.done) begin
        e_busy = 1; e_i = !t.is_d; e_d = t.is_d;
      end
    end
    chk("busy", busy, e_busy);
    chk("mem_ren", mem_ren, e_ren);
    chk("mem_wen", mem_wen, e_wen);
    chk("i_done", i_done, e_i);
    chk("d_done", d_done, e_d);
    if (e_i || e_d) begin
      chk("i_rdata", i_rdata, t.rd_i);
      chk("d_rdata", d_rdata, t.rd_d);
      done_log = {done_log[6:0], t.is_d};
      head++;
    end
  endtask

  task automatic tick();
    @(negedge clock);
    if (cmp_on) compare();
  endtask

  task automatic preload(input logic [7:0] a, input logic [31:0] v);
    pl_en = 1; pl_addr = a; pl_dat = v; ref_mem[a] = v;
    tick();
    pl_en = 0;
  endtask

  // One access from idle; counts enable cycles seen, ends back in idle.
  task automatic run1(input bit is_d, input bit we, input logic [31:0] a,
                      input logic [31:0] wd, output int nren, output int nwen);
    nren = 0; nwen = 0;
    if (is_d) begin d_req = 1; d_we = we; d_addr = a; d_wdata = wd; end
    else begin i_req = 1; i_addr = a; end
    expect_txn(is_d, we, a, wd, cyc + 1);
    repeat (L + 1) begin
      tick();
      nren += int'(mem_ren); nwen += int'(mem_wen);
    end
    i_req = 0; d_req = 0;
    tick();
  endtask

  initial begin
    int nr, nw, base, dj;
    bit win_d;

    tick(); tick();
    chk("rst_i_rdata", i_rdata, 32'h0);
    chk("rst_d_rdata", d_rdata, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    reset = 1;
    tick();

    preload(8'h10, 32'hCAFE0001);
    preload(8'h30, 32'h11113333);
    preload(8'h40, 32'h44440000);

    run1(0, 0, 32'h10, 32'h0, nr, nw);
    chk("i_read_ren_cycles", nr, 2);
    chk("i_read_data", i_rdata, 32'hCAFE0001);

    run1(1, 1, 32'h20, 32'h12345678, nr, nw);
    chk("d_write_wen_cycles", nw, 2);
    chk("d_write_ren_cycles", nr, 0);
    run1(1, 0, 32'h20, 32'h0, nr, nw);
    chk("d_read_data", d_rdata, 32'h12345678);
    chk("i_rdata_held", i_rdata, 32'hCAFE0001);

    // Upper address bits pass straight through to the memory port.
    run1(0, 0, 32'hABCDE010, 32'h0, nr, nw);

    // Simultaneous requests: D first, I one full access period later.
    i_req = 1; i_addr = 32'h30; d_req = 1; d_we = 0; d_addr = 32'h40;
    expect_txn(1, 0, 32'h40, 32'h0, cyc + 1);
    expect_txn(0, 0, 32'h30, 32'h0, cyc + 1 + L + 2);
    repeat (L + 1) tick();
    d_req = 0;
    repeat (L + 2) tick();
    i_req = 0;
    tick();
    chk("sim_order", done_log[1:0], 2'b10);
    chk("sim_i_data", i_rdata, 32'h11113333);
    chk("sim_d_data", d_rdata, 32'h44440000);

    // Sustained contention: both ports re-request right after each completion.
    dj = 0;
    i_req = 1; i_addr = 32'h50;
    d_req = 1; d_we = 1; d_addr = 32'h50; d_wdata = 32'hD0000000;
    base = cyc + 1;
    for (int k = 0; k < 4; k++) begin
`ifdef ARB_ROUND_ROBIN_EN
      win_d = (k % 2 == 0);
`else
      win_d = 1'b1;
`endif
      if (win_d) expect_txn(1, 1, d_addr, d_wdata, base + k * (L + 2));
      else expect_txn(0, 0, i_addr, 32'h0, base + k * (L + 2));
      repeat (L + 1) tick();
      if (win_d) d_req = 0; else i_req = 0;
      tick();
      if (win_d) begin
        dj++; d_addr = 32'h50 + dj; d_wdata = 32'hD0000000 + dj; d_req = 1;
      end else begin
        i_req = 1;
      end
    end
    d_req = 0;
    expect_txn(0, 0, i_addr, 32'h0, base + 4 * (L + 2));
    repeat (L + 1) tick();
    i_req = 0;
    tick();
`ifdef ARB_ROUND_ROBIN_EN
    chk("grant_order", done_log[4:0], 5'b10100);
`else
    chk("grant_order", done_log[4:0], 5'b11110);
`endif
    chk("contend_i_data", i_rdata, 32'hD0000000);

    // Reset mid-access: enables and busy drop at once, no done pulse follows.
    cmp_on = 0;
    i_req = 1; i_addr = 32'h10;
    tick();
    chk("pre_rst_ren", mem_ren, 1'b1);
    chk("pre_rst_busy", busy, 1'b1);
    #2 reset = 0;
    #1;
    chk("rst_ren", mem_ren, 1'b0);
    chk("rst_wen", mem_wen, 1'b0);
    chk("rst_busy", busy, 1'b0);
    i_req = 0;
    last_i = '0; last_d = '0;
    cmp_on = 1;
    tick(); tick();
    chk("rst_i_rdata_clr", i_rdata, 32'h0);
    reset = 1;
    tick();
    run1(0, 0, 32'h30, 32'h0, nr, nw);
    chk("post_rst_i_data", i_rdata, 32'h11113333);
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
